// File: rtl/mcb_cmd_seq_np_if.sv
// mcb_cmd_seq_np_if: request handshake between the upstream scheduler and the command sequencer
//  mcb_bb    request strobe
//  mcb_wr_n  0 = write, 1 = read
//  mcb_bl    burst count minus one
//  mcb_row   request row, used for open-page hit/miss
//  mcb_busy  sequencer cannot take a request this cycle
interface mcb_cmd_seq_np_if #(
  parameter int BL_W  = 3,
  parameter int ROW_W = 13
);
  logic             mcb_bb;
  logic             mcb_wr_n;
  logic [BL_W-1:0]  mcb_bl;
  logic [ROW_W-1:0] mcb_row;
  logic             mcb_busy;
  modport master (output mcb_bb, mcb_wr_n, mcb_bl, mcb_row, input mcb_busy);
  modport slave (input mcb_bb, mcb_wr_n, mcb_bl, mcb_row, output mcb_busy);
endinterface

// File: rtl/mcb_cmd_seq_np.sv
// mcb_cmd_seq_np: parametrised SDR SDRAM command sequencer (ACT/RD/RDA/WR/WRA/PRE/REF pulses)
//  mcb_clk, mcb_rst_n        clock, async active-low reset
//  mcb_sclr_n                sync clear, returns to INIT
//  req                       request handshake (slave side)
//  i_ready                   init sequencer done
//  r_ref_req, r_ref_alert    refresh request (level) / refresh imminent
//  c_bst_num, c_bst_idx      latched burst count-1 / index of next column burst
//  c_ready, c_row_open       FSM idle / a row is tracked open
//  c_ref..c_wra              one-cycle command pulses
//  c_wdat_req                write-data fetch, one cycle before every WR/WRA
module mcb_cmd_seq_np #(
  parameter int BL_W      = 3,
  parameter int ROW_W     = 13,
  parameter int CNT_W     = 5,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_BST     = 4,
  parameter int T_REC_W   = 4,
  parameter int T_REC_R   = 4,
  parameter bit OPEN_PAGE = 1'b0
) (
  input  logic            mcb_clk,
  input  logic            mcb_rst_n,
  input  logic            mcb_sclr_n,
  mcb_cmd_seq_np_if.slave req,
  input  logic            i_ready,
  input  logic            r_ref_req,
  input  logic            r_ref_alert,
  output logic [BL_W-1:0] c_bst_num,
  output logic [BL_W-1:0] c_bst_idx,
  output logic            c_ready,
  output logic            c_row_open,
  output logic            c_ref,
  output logic            c_pre,
  output logic            c_act,
  output logic            c_rd,
  output logic            c_rda,
  output logic            c_wr,
  output logic            c_wra,
  output logic            c_wdat_req
);
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PRE, S_TRP, S_REF, S_TRFC, S_ACT, S_TRCD, S_BST, S_RCV
  } state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr, r_last, r_to_ref;
  logic [ROW_W-1:0] r_row, r_open_row;
  logic             w_acc, w_hit, w_col, w_wr, w_last, w_auto;
  logic [BL_W-1:0]  w_idx, w_num;
  // A wait state is entered one cycle after its command with the counter at 0,
  // so an N-cycle interval ends when the counter reaches N-2.
  function automatic logic f_due(input logic [CNT_W-1:0] cnt, input int n);
    return cnt == CNT_W'(n - 2);
  endfunction
  // w_col looks one cycle ahead: a column command fires next cycle. It also
  // drives c_wdat_req, which must lead the WR/WRA by one cycle (even on a hit
  // where the lead cycle is the accept cycle itself).
  always_comb begin
    w_acc = r_state == S_IDLE && req.mcb_bb && !r_ref_req;
    w_hit = OPEN_PAGE && c_row_open && req.mcb_row == r_open_row;
    w_wr = w_acc ? !req.mcb_wr_n : r_wr;
    w_idx = w_acc ? '0 : c_bst_idx;
    w_num = w_acc ? req.mcb_bl : c_bst_num;
    w_last = w_idx == w_num;
    w_auto = w_last && !OPEN_PAGE;
    w_col = mcb_sclr_n && ((w_acc && w_hit) || (r_state == S_ACT && T_RCD == 1) ||
            (r_state == S_TRCD && f_due(r_cnt, T_RCD)) ||
            (r_state == S_BST && !r_last && r_cnt == CNT_W'(T_BST - 1)));
    c_wdat_req = w_col && w_wr;
    req.mcb_busy = !(c_ready && !r_ref_alert && !req.mcb_bb);
  end
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_state <= S_INIT;
      r_cnt <= '0;
      r_wr <= 1'b0;
      r_last <= 1'b0;
      r_to_ref <= 1'b0;
      r_row <= '0;
      r_open_row <= '0;
      c_bst_num <= '0;
      c_bst_idx <= '0;
      c_ready <= 1'b0;
      c_row_open <= 1'b0;
      {c_ref, c_pre, c_act, c_rd, c_rda, c_wr, c_wra} <= '0;
    end else begin
      {c_ref, c_pre, c_act, c_rd, c_rda, c_wr, c_wra} <= '0;
      c_ready <= 1'b0;
      r_cnt <= r_cnt + 1'b1;
      if (!mcb_sclr_n) begin
        r_state <= S_INIT;
        r_cnt <= '0;
        r_last <= 1'b0;
        c_bst_num <= '0;
        c_bst_idx <= '0;
        c_row_open <= 1'b0;
      end else begin
        case (r_state)
          S_INIT:
            if (i_ready) begin
              r_state <= S_IDLE;
              r_cnt <= '0;
              c_ready <= 1'b1;
            end
          S_IDLE: begin
            if (w_acc) begin
              r_wr <= !req.mcb_wr_n;
              r_row <= req.mcb_row;
              c_bst_num <= req.mcb_bl;
              c_bst_idx <= '0;
            end
            // A refresh wins over a simultaneous strobe; that request is dropped.
            if (r_ref_req) begin
              r_state <= c_row_open ? S_PRE : S_REF;
              r_cnt <= '0;
              r_to_ref <= 1'b1;
              c_pre <= c_row_open;
              c_ref <= !c_row_open;
              c_row_open <= 1'b0;
            end else if (w_acc && !w_hit) begin
              r_state <= c_row_open ? S_PRE : S_ACT;
              r_cnt <= '0;
              r_to_ref <= 1'b0;
              c_pre <= c_row_open;
              c_act <= !c_row_open;
              c_row_open <= OPEN_PAGE && !c_row_open;
              r_open_row <= req.mcb_row;
            end else if (!w_acc) c_ready <= 1'b1;
          end
          S_PRE, S_TRP:
            if (r_state == S_TRP ? f_due(r_cnt, T_RP) : T_RP == 1) begin
              r_state <= r_to_ref ? S_REF : S_ACT;
              r_cnt <= '0;
              c_ref <= r_to_ref;
              c_act <= !r_to_ref;
              c_row_open <= OPEN_PAGE && !r_to_ref;
              r_open_row <= r_row;
            end else if (r_state == S_PRE) begin
              r_state <= S_TRP;
              r_cnt <= '0;
            end
          S_REF, S_TRFC:
            if (r_state == S_TRFC ? f_due(r_cnt, T_RFC) : T_RFC == 1) begin
              r_state <= S_IDLE;
              r_cnt <= '0;
              c_ready <= 1'b1;
            end else if (r_state == S_REF) begin
              r_state <= S_TRFC;
              r_cnt <= '0;
            end
          S_ACT: begin
            r_state <= S_TRCD;
            r_cnt <= '0;
          end
          S_BST:
            if (r_last) begin
              r_state <= (r_wr ? T_REC_W : T_REC_R) == 1 ? S_IDLE : S_RCV;
              r_cnt <= '0;
              c_ready <= (r_wr ? T_REC_W : T_REC_R) == 1;
            end
          S_RCV:
            if (f_due(r_cnt, r_wr ? T_REC_W : T_REC_R)) begin
              r_state <= S_IDLE;
              r_cnt <= '0;
              c_ready <= 1'b1;
            end
          default: ;
        endcase
        // Column command overrides whatever the state case chose; the index
        // saturates on the last burst so a full 2**BL_W request never wraps.
        if (w_col) begin
          r_state <= S_BST;
          r_cnt <= '0;
          r_last <= w_last;
          c_rd <= !w_wr && !w_auto;
          c_rda <= !w_wr && w_auto;
          c_wr <= w_wr && !w_auto;
          c_wra <= w_wr && w_auto;
          c_bst_idx <= w_last ? w_idx : w_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mcb_cmd_seq_np.sv
// tb_mcb_cmd_seq_np: two sequencers (close-page and open-page) checked against a timing-table model
module tb_mcb_cmd_seq_np;
  localparam int BL_W = 3;
  localparam int ROW_W = 13;
  localparam int P_RCD [2] = '{2, 1};
  localparam int P_RP [2] = '{2, 3};
  localparam int P_RFC [2] = '{7, 6};
  localparam int P_BST [2] = '{4, 2};
  localparam int P_RECW [2] = '{4, 5};
  localparam int P_RECR [2] = '{4, 1};
  // event codes: bit position of the pulse in cmd[], 7 = write-data request
  localparam int E_WRA = 0, E_WR = 1, E_RDA = 2, E_RD = 3, E_ACT = 4, E_PRE = 5, E_REF = 6, E_WDAT = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic sclr_n [2], i_rdy [2], ref_req [2], alert [2], bb [2], wr_n [2];
  logic [BL_W-1:0] bl;
  logic [ROW_W-1:0] row;
  logic [BL_W-1:0] num [2], idx [2];
  logic rdy [2], opn [2], wdat [2], busy [2];
  logic [6:0] cmd [2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [6:0] c;
    mcb_cmd_seq_np_if #(.BL_W(BL_W), .ROW_W(ROW_W)) bus ();
    assign bus.mcb_bb = bb[g];
    assign bus.mcb_wr_n = wr_n[g];
    assign bus.mcb_bl = bl;
    assign bus.mcb_row = row;
    assign busy[g] = bus.mcb_busy;
    assign cmd[g] = c;
    mcb_cmd_seq_np #(
      .BL_W(BL_W), .ROW_W(ROW_W), .CNT_W(5), .T_RCD(P_RCD[g]), .T_RP(P_RP[g]), .T_RFC(P_RFC[g]),
      .T_BST(P_BST[g]), .T_REC_W(P_RECW[g]), .T_REC_R(P_RECR[g]), .OPEN_PAGE(1'(g))
    ) dut (
      .mcb_clk(clk), .mcb_rst_n(rst_n), .mcb_sclr_n(sclr_n[g]), .req(bus),
      .i_ready(i_rdy[g]), .r_ref_req(ref_req[g]), .r_ref_alert(alert[g]),
      .c_bst_num(num[g]), .c_bst_idx(idx[g]), .c_ready(rdy[g]), .c_row_open(opn[g]),
      .c_ref(c[6]), .c_pre(c[5]), .c_act(c[4]), .c_rd(c[3]), .c_rda(c[2]), .c_wr(c[1]), .c_wra(c[0]),
      .c_wdat_req(wdat[g])
    );
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int obs [2][$];
  always @(negedge clk)
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < 7; b++) if (cmd[g][b]) obs[g].push_back(cyc * 8 + b);
      if (wdat[g]) obs[g].push_back(cyc * 8 + E_WDAT);
    end
  int n_cmp = 0;
  int n_bad = 0;
  bit m_open [2];
  int m_row [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // One request and/or refresh on sequencer g; the expected trace is built
  // from the timing table as (cycle offset from accept)*8 + event code.
  task automatic xact(input int g, input bit do_req, input bit w, input int b, input int r, input bit do_ref);
    int t, off, rdy_off, n, c;
    int exp_q[$], got[$];
    n = 0;
    while (!rdy[g] && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("idle_before_g%0d", g), rdy[g], 1);
    obs[g].delete();
    t = cyc;
    bb[g] = do_req;
    wr_n[g] = !w;
    bl = BL_W'(b);
    row = ROW_W'(r);
    ref_req[g] = do_ref;
    off = 1;
    if (do_ref) begin
      if (m_open[g]) begin
        exp_q.push_back(off * 8 + E_PRE);
        off += P_RP[g];
      end
      exp_q.push_back(off * 8 + E_REF);
      rdy_off = off + P_RFC[g];
      m_open[g] = 0;
    end else begin
      if (!(g == 1 && m_open[g] && m_row[g] == r)) begin
        if (m_open[g]) begin
          exp_q.push_back(off * 8 + E_PRE);
          off += P_RP[g];
        end
        exp_q.push_back(off * 8 + E_ACT);
        off += P_RCD[g];
      end
      for (int k = 0; k <= b; k++) begin
        c = w ? ((k == b && g == 0) ? E_WRA : E_WR) : ((k == b && g == 0) ? E_RDA : E_RD);
        if (w) exp_q.push_back((off - 1) * 8 + E_WDAT);
        exp_q.push_back(off * 8 + c);
        if (k < b) off += P_BST[g];
      end
      rdy_off = off + (w ? P_RECW[g] : P_RECR[g]);
      if (g == 1) begin
        m_open[g] = 1;
        m_row[g] = r;
      end
    end
    n = 0;
    do begin
      tick();
      bb[g] = 1'b0;
      if (cmd[g][E_REF]) ref_req[g] = 1'b0;
      n++;
    end while (!rdy[g] && n < 300);
    ref_req[g] = 1'b0;
    chk($sformatf("ready_cycle_g%0d", g), cyc - t, rdy_off);
    got = obs[g];
    foreach (got[i]) got[i] -= t * 8;
    got.sort();
    exp_q.sort();
    chk($sformatf("event_count_g%0d", g), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("event%0d_g%0d", i, g), got[i], exp_q[i]);
  endtask
  initial begin
    int n, k, g;
    bit rf;
    for (int i = 0; i < 2; i++) begin
      sclr_n[i] = 1'b1;
      i_rdy[i] = 1'b0;
      ref_req[i] = 1'b0;
      alert[i] = 1'b0;
      bb[i] = 1'b0;
      wr_n[i] = 1'b1;
      m_open[i] = 0;
      m_row[i] = 0;
    end
    bl = '0;
    row = '0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd", cmd[i], 0);
      chk("rst_wdat", wdat[i], 0);
      chk("rst_ready", rdy[i], 0);
      chk("rst_open", opn[i], 0);
      chk("rst_idx", idx[i], 0);
      chk("rst_num", num[i], 0);
      chk("rst_busy", busy[i], 1);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      chk("init_ready", rdy[i], 0);
      chk("init_busy", busy[i], 1);
      chk("init_cmd", cmd[i], 0);
      i_rdy[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("idle_ready", rdy[i], 1);
      chk("idle_busy", busy[i], 0);
    end
    xact(0, 1, 1, 3, 0, 0);
    xact(1, 1, 0, 2, 5, 0);
    xact(1, 1, 0, 0, 5, 0);
    xact(1, 1, 0, 1, 9, 0);
    chk("open_after_miss", opn[1], 1);
    xact(1, 1, 1, 1, 9, 0);
    xact(1, 1, 0, 3, 9, 1);
    chk("open_after_ref", opn[1], 0);
    alert[0] = 1'b1;
    #1;
    chk("alert_busy", busy[0], 1);
    alert[0] = 1'b0;
    #1;
    chk("alert_clear_busy", busy[0], 0);
    bb[0] = 1'b1;
    #1;
    chk("strobe_busy", busy[0], 1);
    bb[0] = 1'b0;
    xact(0, 1, 0, 7, 0, 0);
    chk("idx_no_wrap_g0", idx[0], 7);
    chk("num_g0", num[0], 7);
    xact(1, 1, 1, 7, 3, 0);
    chk("idx_no_wrap_g1", idx[1], 7);
    repeat (60) begin
      g = int'($urandom_range(0, 1));
      rf = $urandom_range(0, 5) == 0;
      xact(g, rf ? 1'($urandom_range(0, 1)) : 1'b1, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), $urandom_range(0, 1) ? 5 : 9, rf);
    end
    n = 0;
    while (!rdy[1] && n < 300) begin
      tick();
      n++;
    end
    bb[1] = 1'b1;
    wr_n[1] = 1'b1;
    bl = 3'd5;
    row = 13'd3;
    n = 0;
    k = 0;
    do begin
      tick();
      bb[1] = 1'b0;
      if (cmd[1][E_RD] || cmd[1][E_RDA]) k++;
      n++;
    end while (k < 2 && n < 100);
    chk("sclr_two_cols", k, 2);
    sclr_n[1] = 1'b0;
    i_rdy[1] = 1'b0;
    tick();
    sclr_n[1] = 1'b1;
    repeat (6) begin
      chk("sclr_quiet", cmd[1], 0);
      tick();
    end
    chk("sclr_idx", idx[1], 0);
    chk("sclr_num", num[1], 0);
    chk("sclr_open", opn[1], 0);
    chk("sclr_ready", rdy[1], 0);
    m_open[1] = 0;
    i_rdy[1] = 1'b1;
    tick();
    chk("sclr_ready_after_init", rdy[1], 1);
    xact(1, 1, 1, 1, 5, 0);
    bb[0] = 1'b1;
    wr_n[0] = 1'b0;
    bl = 3'd7;
    tick();
    bb[0] = 1'b0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_cmd", cmd[i], 0);
      chk("arst_wdat", wdat[i], 0);
      chk("arst_ready", rdy[i], 0);
      chk("arst_idx", idx[i], 0);
      chk("arst_num", num[i], 0);
      chk("arst_busy", busy[i], 1);
      m_open[i] = 0;
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) chk("arst_ready_after", rdy[i], 1);
    xact(0, 1, 1, 0, 0, 0);
    xact(1, 1, 0, 2, 9, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
